// File: rtl/biplex_pkg.sv
// Shared definitions for the biplex FFT reorder path: frame-sequencer state
// codes, default counter bus width and phase encoding.
package biplex_pkg;

  localparam int unsigned COUNT_W_DEFAULT = 34;

  // Frame sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLR  = 2'd1;
  localparam logic [1:0] ST_UP   = 2'd2;
  localparam logic [1:0] ST_DOWN = 2'd3;

  typedef logic [1:0] state_t;

  // Values driven on the phase output
  localparam logic PHASE_UP = 1'b0;
  localparam logic PHASE_DN = 1'b1;

endpackage

// File: rtl/biplex_frame_ctrl.sv
// Frame sequencer for the biplex FFT reorder path. Drives an external up/down
// address counter through alternating ascending (0..N-1) and descending
// (N-1..0) phases of N cycles each, aligned to sync_in.
// Optional feature macro: BIPLEX_FRAME_CTRL_RESYNC_EN (restart on a misaligned
// sync_in and raise the sticky sync_err flag).
module biplex_frame_ctrl
  import biplex_pkg::*;
#(
  parameter int unsigned FFT_BITS = 5,
  parameter int unsigned COUNT_W  = COUNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sync_in,
  input  logic [COUNT_W-1:0] count_in,
  output logic               cnt_ena,
  output logic               cnt_updown,
  output logic               cnt_rst,
  output logic               sync_out,
  output logic               phase,
  output logic               busy
`ifdef BIPLEX_FRAME_CTRL_RESYNC_EN
  ,
  output logic               sync_err
`endif
);

  // Last address of a phase, N-1
  localparam logic [FFT_BITS-1:0] TOP = '1;

  state_t              state;
  state_t              state_nxt;
  logic [FFT_BITS-1:0] cnt_lo;
  logic                at_top;
  logic                at_zero;
  logic                resync_c;
  logic                unused_cnt_hi;

  // Only the low FFT_BITS of the counter carry the address
  assign cnt_lo        = count_in[FFT_BITS-1:0];
  assign unused_cnt_hi = ^count_in[COUNT_W-1:FFT_BITS];
  assign at_top        = (cnt_lo == TOP);
  assign at_zero       = (cnt_lo == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode from state and current count
  always_comb begin
    state_nxt  = state;
    cnt_ena    = 1'b0;
    cnt_updown = 1'b1;
    cnt_rst    = 1'b0;
    sync_out   = 1'b0;
    phase      = PHASE_UP;
    busy       = (state != ST_IDLE);
    resync_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sync_in && en) begin
          state_nxt = ST_CLR;
        end
      end
      ST_CLR: begin
        cnt_rst   = 1'b1;
        state_nxt = ST_UP;
      end
      ST_UP: begin
        cnt_ena  = !at_top;
        sync_out = at_zero;
        if (at_top) begin
          state_nxt = ST_DOWN;
        end
`ifdef BIPLEX_FRAME_CTRL_RESYNC_EN
        if (sync_in) begin
          state_nxt = ST_CLR;
          resync_c  = 1'b1;
        end
`endif
      end
      ST_DOWN: begin
        cnt_updown = 1'b0;
        phase      = PHASE_DN;
        cnt_ena    = !at_zero;
        if (at_zero) begin
          // A sync_in here is frame-aligned and needs no restart
          state_nxt = en ? ST_UP : ST_IDLE;
        end
`ifdef BIPLEX_FRAME_CTRL_RESYNC_EN
        else if (sync_in) begin
          state_nxt = ST_CLR;
          resync_c  = 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef BIPLEX_FRAME_CTRL_RESYNC_EN
  // Sticky flag recording any misaligned sync since reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_err <= 1'b0;
    end else if (resync_c) begin
      sync_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_biplex_frame_ctrl.sv
// Bench for biplex_frame_ctrl with N=8 and a behavioural up/down counter.
// Expected behaviour comes from a frame-position model: position p within
// a 2N-cycle frame gives address p (p<N) or 2N-1-p (p>=N).
module tb_biplex_frame_ctrl;
  import biplex_pkg::*;

  localparam int unsigned FB = 3;
  localparam int          N  = 8;
  localparam int unsigned CW = 34;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          sync_in = 1'b0;
  logic [CW-1:0] count_in = '0;
  logic          cnt_ena;
  logic          cnt_updown;
  logic          cnt_rst;
  logic          sync_out;
  logic          phase;
  logic          busy;
`ifdef BIPLEX_FRAME_CTRL_RESYNC_EN
  logic          sync_err;
`endif

  biplex_frame_ctrl #(.FFT_BITS(FB), .COUNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sync_in    (sync_in),
    .count_in   (count_in),
    .cnt_ena    (cnt_ena),
    .cnt_updown (cnt_updown),
    .cnt_rst    (cnt_rst),
    .sync_out   (sync_out),
    .phase      (phase),
    .busy       (busy)
`ifdef BIPLEX_FRAME_CTRL_RESYNC_EN
    ,
    .sync_err   (sync_err)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural address counter
  always @(posedge clk) begin
    if (cnt_rst) count_in <= '0;
    else if (cnt_ena) count_in <= cnt_updown ? count_in + CW'(1) : count_in - CW'(1);
  end

  // Model: mode 0 idle, 1 clearing, 2 running at frame position pos
  int            mode = 0;
  int            pos = 0;
  logic          merr = 1'b0;
  logic [CW-1:0] mcnt = '0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (mode=%0d pos=%0d)", tag, act, exp, mode, pos);
    end
  endtask

  // Expected {ena, updown, rst, sync_out, phase, busy}
  function automatic logic [5:0] expect_vec();
    logic e_ena, e_up, e_rst, e_sync, e_ph, e_busy;
    e_ena = 1'b0; e_up = 1'b1; e_rst = 1'b0; e_sync = 1'b0; e_ph = 1'b0; e_busy = 1'b0;
    if (mode == 1) begin
      e_rst = 1'b1; e_busy = 1'b1;
    end else if (mode == 2) begin
      e_busy = 1'b1;
      e_ph   = (pos >= N);
      e_up   = !e_ph;
      e_ena  = (pos != N - 1) && (pos != 2 * N - 1);
      e_sync = (pos == 0);
    end
    return {e_ena, e_up, e_rst, e_sync, e_ph, e_busy};
  endfunction

  task automatic check_all();
    logic [5:0] v;
    v = expect_vec();
    chk("cnt_ena",    CW'(cnt_ena),    CW'(v[5]));
    chk("cnt_updown", CW'(cnt_updown), CW'(v[4]));
    chk("cnt_rst",    CW'(cnt_rst),    CW'(v[3]));
    chk("sync_out",   CW'(sync_out),   CW'(v[2]));
    chk("phase",      CW'(phase),      CW'(v[1]));
    chk("busy",       CW'(busy),       CW'(v[0]));
    chk("count",      count_in,        mcnt);
    if (mode == 2)
      chk("addr", mcnt, (pos < N) ? CW'(pos) : CW'(2 * N - 1 - pos));
`ifdef BIPLEX_FRAME_CTRL_RESYNC_EN
    chk("sync_err",   CW'(sync_err),   CW'(merr));
`endif
  endtask

  // Model step on a rising edge using the inputs the DUT sampled
  task automatic advance(input logic s, input logic e);
    logic [5:0] v;
    v = expect_vec();
    if (v[3]) mcnt = '0;
    else if (v[5]) mcnt = v[4] ? mcnt + CW'(1) : mcnt - CW'(1);
    if (rst) begin
      mode = 0; merr = 1'b0;
    end else begin
      case (mode)
        0: if (s && e) mode = 1;
        1: begin mode = 2; pos = 0; end
        default: begin
          if (pos == 2 * N - 1) begin
            if (e) pos = 0;
            else mode = 0;
          end
`ifdef BIPLEX_FRAME_CTRL_RESYNC_EN
          else if (s) begin
            mode = 1; merr = 1'b1;
          end
`endif
          else pos++;
        end
      endcase
    end
  endtask

  task automatic cycle(input logic s, input logic e, input logic r);
    @(negedge clk);
    sync_in = s; en = e; rst = r;
    if (r) begin mode = 0; merr = 1'b0; end
    #1 check_all();
    @(posedge clk);
    advance(s, e);
  endtask

  // Run with en=1 until the model reaches frame position p
  task automatic wait_pos(input int p);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 4 * N; i++) begin
      if (mode == 2 && pos == p) begin
        found = 1'b1;
        break;
      end
      cycle(1'b0, 1'b1, 1'b0);
    end
    chk("reach_pos", CW'(found), CW'(1));
  endtask

  // Reset asserted between edges; outputs must react without a clock
  task automatic async_reset();
    @(negedge clk);
    sync_in = 1'b0;
    #1 check_all();
    #1 rst = 1'b1;
    mode = 0; merr = 1'b0;
    #1 check_all();
    @(posedge clk);
    advance(1'b0, en);
  endtask

  initial begin
    // Reset state, then sync with en low is ignored
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (7) cycle(1'b0, 1'b1, 1'b0);
    // Basic frame: two full frames
    cycle(1'b1, 1'b1, 1'b0);
    repeat (4 * N + 2) cycle(1'b0, 1'b1, 1'b0);
    // Stop on en dropped mid up-phase
    wait_pos(3);
    repeat (2 * N + 4) cycle(1'b0, 1'b0, 1'b0);
    // Aligned sync on the last down-phase cycle
    cycle(1'b1, 1'b1, 1'b0);
    wait_pos(2 * N - 1);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    // Misaligned sync at address 4 of an up-phase
    wait_pos(4);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (2 * N + 2) cycle(1'b0, 1'b1, 1'b0);
    // Reset during the down-phase, then restart
    wait_pos(N + 2);
    async_reset();
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (2 * N + 2) cycle(1'b0, 1'b1, 1'b0);
    // Random traffic
    for (int i = 0; i < 800; i++) begin
      cycle(1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 149) == 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
